sed_monitor: RTL and testbench



---
 rtl/sed_monitor_if.sv | 39 +++
 rtl/sed_monitor.sv | 182 ++++++++++++++++++
 tb/tb_sed_monitor.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sed_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : sed_monitor_if
// Brief    : Control, SED primitive and status signals of sed_monitor.
// Revision : 1.0  initial release
// ============================================================================
interface sed_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             start;
  logic             frc_req;
  logic             err_clr;
  logic             sedinprog;
  logic             seddone;
  logic             sederr;
  logic             sedenable;
  logic             sedstart;
  logic             sedfrcerr;
  logic             busy;
  logic             chk_done;
  logic             err_flag;
  logic [CNT_W-1:0] err_cnt;
  logic             tout_flag;
  logic             frc_fail;

  modport master (
    output en, start, frc_req, err_clr, sedinprog, seddone, sederr,
    input  sedenable, sedstart, sedfrcerr, busy, chk_done,
           err_flag, err_cnt, tout_flag, frc_fail
  );

  modport slave (
    input  en, start, frc_req, err_clr, sedinprog, seddone, sederr,
    output sedenable, sedstart, sedfrcerr, busy, chk_done,
           err_flag, err_cnt, tout_flag, frc_fail
  );
endinterface
`default_nettype wire

// File: rtl/sed_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sed_monitor
// Brief    : Schedules SED checks, injects forced-error self-tests, reports.
// Revision : 1.0  initial release
// ============================================================================
module sed_monitor #(
  parameter int PERIOD  = 1024,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  sed_monitor_if.slave bus
);
  localparam int c_tmr_w = $clog2((PERIOD > TIMEOUT + 1) ? PERIOD : TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_period_ld  = c_tmr_w'(PERIOD - 1);
  localparam logic [c_tmr_w-1:0] c_timeout_ld = c_tmr_w'(TIMEOUT);
  localparam logic [CNT_W-1:0]   c_cnt_max    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_WAIT = 3'd2,
    S_ARM  = 3'd3,
    S_RUN  = 3'd4,
    S_EVAL = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_tmr_w-1:0] r_tmr;
  logic [2:0]         r_meta, r_sync;
  logic               r_by_start, r_pending, r_forced, r_seen, r_tout, r_res_err;
  logic               r_sedenable, r_sedstart, r_sedfrcerr, r_busy, r_chk_done;
  logic               r_err_flag, r_tout_flag, r_frc_fail;
  logic [CNT_W-1:0]   r_err_cnt;

  logic w_s_inprog, w_s_done, w_s_err;
  logic w_frc_now, w_to_arm, w_eval_ok, w_set_err, w_set_tout, w_set_ffail;

  // The SED status lines come from another clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 3'b000;
      r_sync <= 3'b000;
    end else begin
      r_meta <= {bus.sedinprog, bus.seddone, bus.sederr};
      r_sync <= r_meta;
    end
  end

  assign w_s_inprog = r_sync[2];
  assign w_s_done   = r_sync[1];
  assign w_s_err    = r_sync[0];

  // A request arriving in the same cycle as the arm decision still counts.
  assign w_frc_now   = r_pending | bus.frc_req;
  assign w_to_arm    = ((r_state == S_PREP) && r_by_start) ||
                       ((r_state == S_WAIT) && (bus.start || (bus.en && (r_tmr == '0))));
  assign w_eval_ok   = (r_state == S_EVAL) && !r_tout;
  assign w_set_err   = w_eval_ok && !r_forced && r_res_err;
  assign w_set_tout  = (r_state == S_EVAL) && r_tout;
  assign w_set_ffail = w_eval_ok && r_forced && !r_res_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_by_start  <= 1'b0;
      r_pending   <= 1'b0;
      r_forced    <= 1'b0;
      r_seen      <= 1'b0;
      r_tout      <= 1'b0;
      r_res_err   <= 1'b0;
      r_sedenable <= 1'b0;
      r_sedstart  <= 1'b0;
      r_sedfrcerr <= 1'b0;
      r_busy      <= 1'b0;
      r_chk_done  <= 1'b0;
      r_err_flag  <= 1'b0;
      r_tout_flag <= 1'b0;
      r_frc_fail  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_sedstart <= 1'b0;
      r_chk_done <= 1'b0;
      if (bus.frc_req) r_pending <= 1'b1;

      if (w_to_arm) begin
        r_state     <= S_ARM;
        r_sedstart  <= 1'b1;
        r_busy      <= 1'b1;
        r_sedfrcerr <= w_frc_now;
        r_forced    <= w_frc_now;
        r_pending   <= 1'b0;
        r_seen      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.en || bus.start) begin
              r_state     <= S_PREP;
              r_sedenable <= 1'b1;
              r_by_start  <= bus.start;
            end
          end
          S_PREP: begin
            r_state <= S_WAIT;
            r_tmr   <= c_period_ld;
          end
          S_WAIT: begin
            if (!bus.en) begin
              r_state     <= S_IDLE;
              r_sedenable <= 1'b0;
            end else begin
              r_tmr <= r_tmr - c_tmr_w'(1);
            end
          end
          S_ARM: begin
            r_state <= S_RUN;
            r_tmr   <= c_timeout_ld;
          end
          S_RUN: begin
            if (w_s_inprog) r_seen <= 1'b1;
            if (r_seen && w_s_done && !w_s_inprog) begin
              r_state     <= S_EVAL;
              r_chk_done  <= 1'b1;
              r_tout      <= 1'b0;
              r_res_err   <= w_s_err;
              r_sedfrcerr <= 1'b0;
            end else if (r_tmr == '0) begin
              r_state     <= S_EVAL;
              r_chk_done  <= 1'b1;
              r_tout      <= 1'b1;
              r_res_err   <= 1'b0;
              r_sedfrcerr <= 1'b0;
            end else begin
              r_tmr <= r_tmr - c_tmr_w'(1);
            end
          end
          S_EVAL: begin
            r_busy <= 1'b0;
            if (bus.en) begin
              r_state <= S_WAIT;
              r_tmr   <= c_period_ld;
            end else begin
              r_state     <= S_IDLE;
              r_sedenable <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_sedenable <= 1'b0;
            r_busy      <= 1'b0;
            r_sedfrcerr <= 1'b0;
          end
        endcase
      end

      // A result reported in the same cycle as a clear takes precedence.
      r_err_flag  <= w_set_err   | (r_err_flag  & ~bus.err_clr);
      r_tout_flag <= w_set_tout  | (r_tout_flag & ~bus.err_clr);
      r_frc_fail  <= w_set_ffail | (r_frc_fail  & ~bus.err_clr);
      if (w_set_err) begin
        if (bus.err_clr)               r_err_cnt <= CNT_W'(1);
        else if (r_err_cnt != c_cnt_max) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end else if (bus.err_clr) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign bus.sedenable = r_sedenable;
  assign bus.sedstart  = r_sedstart;
  assign bus.sedfrcerr = r_sedfrcerr;
  assign bus.busy      = r_busy;
  assign bus.chk_done  = r_chk_done;
  assign bus.err_flag  = r_err_flag;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.tout_flag = r_tout_flag;
  assign bus.frc_fail  = r_frc_fail;
endmodule
`default_nettype wire

// File: tb/tb_sed_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sed_monitor
// Brief    : Directed bench for sed_monitor with a behavioural SED primitive.
// Revision : 1.0  initial release
// ============================================================================
module tb_sed_monitor;
  localparam int PERIOD  = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   err_mode;      // 0 never, 1 always, 2 only when the check was forced
  bit   model_silent;

  sed_monitor_if #(.CNT_W(CNT_W)) bus ();

  sed_monitor #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SED primitive: SEDINPROG for 20 cycles starting 5 cycles after SEDSTART,
  // then SEDDONE (and SEDERR, depending on err_mode) held until the next start.
  int m_cnt;
  bit m_active;
  bit m_frc;
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_cnt <= 0;
      m_frc <= 1'b0;
      bus.sedinprog <= 1'b0;
      bus.seddone <= 1'b0;
      bus.sederr <= 1'b0;
    end else if (bus.sedstart) begin
      m_active <= !model_silent;
      m_cnt <= 1;
      m_frc <= bus.sedfrcerr;
      bus.sedinprog <= 1'b0;
      bus.seddone <= 1'b0;
      bus.sederr <= 1'b0;
    end else if (m_active && m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
      bus.sedinprog <= (m_cnt + 1 >= 5) && (m_cnt + 1 <= 24);
      bus.seddone <= (m_cnt + 1 >= 25);
      bus.sederr <= (m_cnt + 1 >= 25) && (err_mode == 1 || (err_mode == 2 && m_frc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_sig(input bit sel_done, input int budget, input string name);
    int k;
    k = 0;
    while (((sel_done ? bus.chk_done : bus.sedstart) !== 1'b1) && k < budget) begin
      step();
      k++;
    end
    check(name, (sel_done ? bus.chk_done : bus.sedstart), 1);
  endtask

  typedef struct {
    int mode;
    bit frc;
    bit clr;
    bit exp_flag;
    int exp_cnt;
    bit exp_ff;
  } vec_t;

  vec_t vec[10];

  initial begin
    int s, last_done, t_en, mism, cnt;
    vec[0] = '{0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vec[1] = '{0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vec[2] = '{1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vec[3] = '{1, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vec[4] = '{1, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vec[5] = '{1, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vec[6] = '{0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vec[7] = '{2, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vec[8] = '{0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    vec[9] = '{2, 1'b0, 1'b0, 1'b0, 0, 1'b1};

    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    err_mode = 0;
    model_silent = 1'b0;
    last_done = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.start = 1'b0;
    bus.frc_req = 1'b0;
    bus.err_clr = 1'b0;

    // Reset state and idle with EN low
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_sedenable", bus.sedenable, 0);
    check("rst_sedstart", bus.sedstart, 0);
    check("rst_sedfrcerr", bus.sedfrcerr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_chk_done", bus.chk_done, 0);
    check("rst_flags", {bus.err_flag, bus.tout_flag, bus.frc_fail}, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sedenable !== 1'b0) cnt++;
    end
    check("idle_sedenable", cnt, 0);

    // Periodic checks driven by the vector table
    bus.en = 1'b1;
    t_en = cyc;
    for (int i = 0; i < 10; i++) begin
      err_mode = vec[i].mode;
      if (vec[i].clr) begin bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0; end
      if (vec[i].frc) begin bus.frc_req = 1'b1; step(); bus.frc_req = 1'b0; end
      wait_sig(1'b0, 100, "vec_start_seen");
      s = cyc;
      if (i == 0) check("first_start_lat", s - t_en, PERIOD + 2);
      else        check("period_lat", s - last_done, PERIOD + 1);
      check("vec_sedfrcerr_arm", bus.sedfrcerr, vec[i].frc);
      check("vec_busy_arm", bus.busy, 1);
      mism = 0;
      for (int k = 0; k < 200 && bus.chk_done !== 1'b1; k++) begin
        step();
        if (bus.chk_done !== 1'b1 && bus.sedfrcerr !== vec[i].frc) mism++;
      end
      check("vec_done_seen", bus.chk_done, 1);
      check("vec_done_lat", cyc - s, 28);
      check("vec_sedfrcerr_run", mism, 0);
      step();
      last_done = cyc - 1;
      check("vec_err_flag", bus.err_flag, vec[i].exp_flag);
      check("vec_err_cnt", bus.err_cnt, vec[i].exp_cnt);
      check("vec_frc_fail", bus.frc_fail, vec[i].exp_ff);
      check("vec_tout_flag", bus.tout_flag, 0);
    end

    // START in WAIT arms on the next cycle
    err_mode = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("wait_start_lat", bus.sedstart, 1);
    wait_sig(1'b1, 200, "wait_start_done");
    step();

    // ERR_CLR in the EVAL cycle of an erroring check
    err_mode = 1;
    wait_sig(1'b0, 100, "clr_start_seen");
    wait_sig(1'b1, 200, "clr_done_seen");
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("clr_eval_flag", bus.err_flag, 1);
    check("clr_eval_cnt", bus.err_cnt, 1);
    check("clr_eval_ff", bus.frc_fail, 0);

    // Drop EN, then a timed-out check started from IDLE
    bus.en = 1'b0;
    repeat (3) step();
    check("en_off_sedenable", bus.sedenable, 0);
    model_silent = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("idle_start_prep", bus.sedstart, 0);
    step();
    check("idle_start_lat", bus.sedstart, 1);
    s = cyc;
    wait_sig(1'b1, 200, "tout_done_seen");
    check("tout_lat", cyc - s, TIMEOUT + 2);
    step();
    check("tout_flag", bus.tout_flag, 1);
    check("tout_err_flag", bus.err_flag, 1);
    check("tout_err_cnt", bus.err_cnt, 1);
    check("tout_busy", bus.busy, 0);
    check("tout_to_idle", bus.sedenable, 0);

    // Forced check interrupted by reset; START during RUN is ignored
    bus.frc_req = 1'b1;
    step();
    bus.frc_req = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("rst_run_sedstart", bus.sedstart, 1);
    check("rst_run_sedfrcerr", bus.sedfrcerr, 1);
    repeat (5) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.sedstart !== 1'b0) cnt++;
      step();
    end
    check("run_start_ignored", cnt, 0);
    check("run_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    check("midrst_sedenable", bus.sedenable, 0);
    check("midrst_sedfrcerr", bus.sedfrcerr, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_flags", {bus.err_flag, bus.tout_flag, bus.frc_fail}, 0);
    check("midrst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.sedenable !== 1'b0 || bus.sedstart !== 1'b0) cnt++;
    end
    check("post_rst_idle", cnt, 0);

    // START in IDLE after reset runs a normal check
    model_silent = 1'b0;
    err_mode = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("post_rst_start_lat", bus.sedstart, 1);
    check("post_rst_sedfrcerr", bus.sedfrcerr, 0);
    s = cyc;
    wait_sig(1'b1, 200, "post_rst_done_seen");
    check("post_rst_done_lat", cyc - s, 28);
    step();
    check("post_rst_flags", {bus.err_flag, bus.tout_flag, bus.frc_fail}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
